// File: rtl/lsu_pkg.sv
// Shared types, width codes and store-merge helper for the load/store unit.
// Imported by the top level and by the load-alignment sub-module.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW,
    S_STORE,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Loads accept all five width codes; stores have no unsigned variants.
  function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic funct3_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Replace the addressed lane of a memory word with the low store bits.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  addr_lo,
                                              input logic [2:0]  funct3);
    logic [31:0] merged;
    merged = word;
    case (funct3)
      F3_B: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-lane extraction: selects the addressed byte or half of a memory word
// and sign- or zero-extends it according to the RV32 width code.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    value     = rdata;
    case (funct3)
      F3_B:    value = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   value = {24'd0, byte_lane};
      F3_H:    value = {{16{half_lane[15]}}, half_lane};
      F3_HU:   value = {16'd0, half_lane};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store initiator for a word-wide memory without byte enables.
// Sub-word stores run as read-modify-write; faults answer in one cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wbuf;
  logic [31:0] load_value;
  logic        req_illegal;
  logic        req_misaligned;

  assign req_illegal    = !funct3_legal(req_write, req_funct3) ||
                          (req_addr >= 32'(MEM_BYTES));
  assign req_misaligned = funct3_misaligned(req_funct3, req_addr[1:0]);

  lsu_load_align u_load_align (
    .rdata   (mem_read_data),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .value   (load_value)
  );

  // Strobes are gated by rst_n so a reset edge can never coincide with a memory write.
  assign req_ready      = rst_n && (state == S_IDLE);
  assign mem_read       = rst_n && ((state == S_LOAD) || (state == S_RMW));
  assign mem_write      = rst_n && (state == S_STORE);
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign mem_write_data = wbuf;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'd0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      wbuf            <= 32'd0;
      funct3_q        <= 3'd0;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_illegal || req_misaligned) begin
              resp_valid      <= 1'b1;
              resp_rdata      <= 32'd0;
              resp_illegal    <= req_illegal;
              resp_misaligned <= !req_illegal;
              state           <= S_RESP;
            end else if (!req_write) begin
              state <= S_LOAD;
            end else if (req_funct3 == F3_W) begin
              wbuf  <= req_wdata;
              state <= S_STORE;
            end else begin
              state <= S_RMW;
            end
          end
        end
        S_LOAD: begin
          resp_valid      <= 1'b1;
          resp_rdata      <= load_value;
          resp_illegal    <= 1'b0;
          resp_misaligned <= 1'b0;
          state           <= S_RESP;
        end
        S_RMW: begin
          wbuf  <= merge_store(mem_read_data, wdata_q, addr_q[1:0], funct3_q);
          state <= S_STORE;
        end
        S_STORE: begin
          resp_valid      <= 1'b1;
          resp_rdata      <= 32'd0;
          resp_illegal    <= 1'b0;
          resp_misaligned <= 1'b0;
          state           <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
